// File: rtl/limp_pkg.sv
// Shared LIMP bus types and handshake helpers.
// Used by every LIMP requestor, target and arbiter.
package limp_pkg;

    localparam int unsigned LIMP_ADDR_W = 32;
    localparam int unsigned LIMP_DATA_W = 32;
    localparam int unsigned LIMP_SIZE_W = 2;

    typedef enum logic [1:0] {
        LIMP_NOP      = 2'd0,
        LIMP_READ     = 2'd1,
        LIMP_WRITE    = 2'd2,
        LIMP_AMO_READ = 2'd3
    } cmd_e;

    typedef enum logic [1:0] {
        LIMP_NOT_READY     = 2'd0,
        LIMP_READY_OK      = 2'd1,
        LIMP_READY_ILLEGAL = 2'd2
    } status_e;

    typedef struct packed {
        cmd_e                   cmd;
        logic [LIMP_ADDR_W-1:0] addr;
        logic [LIMP_DATA_W-1:0] wdata;
        logic [LIMP_SIZE_W-1:0] size;
    } req_s;

    typedef struct packed {
        status_e                status;
        logic [LIMP_DATA_W-1:0] rdata;
    } rsp_s;

    function automatic logic req_valid(input req_s req);
        return req.cmd != LIMP_NOP;
    endfunction

    // An ILLEGAL answer still ends the transfer.
    function automatic logic rsp_ready(input rsp_s rsp);
        return rsp.status != LIMP_NOT_READY;
    endfunction

    function automatic logic transfer_complete_at_posedge(input req_s req, input rsp_s rsp);
        return req_valid(req) && rsp_ready(rsp);
    endfunction

endpackage

// File: rtl/limp_arb2.sv
// Two-port LIMP arbiter with combinational pass-through to one target.
// Holds the grant across wait states and across an AMO read/write sequence.
module limp_arb2
    import limp_pkg::*;
#(
    parameter bit FAIR = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  req_s i_req0,
    output rsp_s o_rsp0,
    input  req_s i_req1,
    output rsp_s o_rsp1,
    output req_s o_req,
    input  rsp_s i_rsp,
    output logic o_owner
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOCK0 = 3'd1,
        ST_LOCK1 = 3'd2,
        ST_AMO0  = 3'd3,
        ST_AMO1  = 3'd4
    } state_e;

    state_e state;
    state_e state_next;
    logic   last_grant;
    logic   last_grant_next;

    logic   valid0;
    logic   valid1;
    logic   fwd_en;
    logic   fwd_sel;
    logic   done;
    req_s   owner_req;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= ST_IDLE;
            last_grant <= 1'b1;
        end else begin
            state      <= state_next;
            last_grant <= last_grant_next;
        end
    end

    // Grant selection, forwarding and next-state decode in one pass.
    always_comb begin
        state_next      = state;
        last_grant_next = last_grant;
        fwd_en          = 1'b0;
        fwd_sel         = 1'b0;
        o_req           = '0;
        o_req.cmd       = LIMP_NOP;
        o_rsp0          = '0;
        o_rsp0.status   = LIMP_NOT_READY;
        o_rsp1          = '0;
        o_rsp1.status   = LIMP_NOT_READY;
        o_owner         = 1'b0;

        valid0 = req_valid(i_req0);
        valid1 = req_valid(i_req1);

        case (state)
            ST_IDLE: begin
                fwd_en = valid0 || valid1;
                if (valid0 && valid1) begin
                    fwd_sel = FAIR ? ~last_grant : 1'b0;
                end else begin
                    fwd_sel = valid1;
                end
            end
            ST_LOCK0, ST_AMO0: begin
                fwd_en  = valid0;
                fwd_sel = 1'b0;
            end
            ST_LOCK1, ST_AMO1: begin
                fwd_en  = valid1;
                fwd_sel = 1'b1;
            end
            default: begin
                fwd_en  = 1'b0;
                fwd_sel = 1'b0;
            end
        endcase

        owner_req = fwd_sel ? i_req1 : i_req0;
        done      = fwd_en && transfer_complete_at_posedge(owner_req, i_rsp);

        if (fwd_en) begin
            o_req   = owner_req;
            o_owner = fwd_sel;
            if (fwd_sel) begin
                o_rsp1 = i_rsp;
            end else begin
                o_rsp0 = i_rsp;
            end
        end

        if (done) begin
            last_grant_next = fwd_sel;
        end

        case (state)
            ST_IDLE: begin
                if (fwd_en) begin
                    if (!done) begin
                        state_next = fwd_sel ? ST_LOCK1 : ST_LOCK0;
                    end else if (owner_req.cmd == LIMP_AMO_READ) begin
                        state_next = fwd_sel ? ST_AMO1 : ST_AMO0;
                    end
                end
            end
            ST_LOCK0, ST_LOCK1: begin
                // Owner dropping its request mid-transfer releases the lock.
                if (!fwd_en) begin
                    state_next = ST_IDLE;
                end else if (done) begin
                    if (owner_req.cmd == LIMP_AMO_READ) begin
                        state_next = fwd_sel ? ST_AMO1 : ST_AMO0;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            ST_AMO0, ST_AMO1: begin
                if (done && owner_req.cmd == LIMP_WRITE) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_limp_arb2.sv
// Directed bench for limp_arb2: fair and fixed-priority instances share stimulus.
// Inputs change 1ns after posedge; outputs are checked 2ns later.
module tb_limp_arb2;
    import limp_pkg::*;

    logic i_clk = 1'b0;
    logic i_rst;
    req_s i_req0, i_req1;
    rsp_s i_rsp;
    rsp_s o_rsp0, o_rsp1, fp_rsp0, fp_rsp1;
    req_s o_req, fp_req;
    logic o_owner, fp_owner;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 i_clk = ~i_clk;

    limp_arb2 #(.FAIR(1'b1)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_req0(i_req0), .o_rsp0(o_rsp0),
        .i_req1(i_req1), .o_rsp1(o_rsp1),
        .o_req(o_req), .i_rsp(i_rsp), .o_owner(o_owner)
    );

    limp_arb2 #(.FAIR(1'b0)) dut_fp (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_req0(i_req0), .o_rsp0(fp_rsp0),
        .i_req1(i_req1), .o_rsp1(fp_rsp1),
        .o_req(fp_req), .i_rsp(i_rsp), .o_owner(fp_owner)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int port, input cmd_e cmd, input logic [31:0] addr);
        req_s r;
        r       = '0;
        r.cmd   = cmd;
        r.addr  = addr;
        r.wdata = addr ^ 32'h5a5a_0000;
        r.size  = 2'd2;
        if (port == 0) i_req0 = r;
        else           i_req1 = r;
    endtask

    task automatic set_rsp(input status_e st, input logic [31:0] rdata);
        i_rsp.status = st;
        i_rsp.rdata  = rdata;
    endtask

    // Advance to just after the next posedge, where new inputs are driven.
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        set_req(0, LIMP_NOP, 32'h0);
        set_req(1, LIMP_NOP, 32'h0);
        set_rsp(LIMP_NOT_READY, 32'h0);
        tick();
        i_rst = 1'b0;
    endtask

    initial begin
        i_rst = 1'b1;
        set_req(0, LIMP_NOP, 32'h0);
        set_req(1, LIMP_NOP, 32'h0);
        set_rsp(LIMP_NOT_READY, 32'h0);
        #1;

        // Reset state with both ports idle.
        tick();
        settle();
        check_eq("rst_cmd",   64'(o_req.cmd), 64'(LIMP_NOP));
        check_eq("rst_rsp0",  64'(o_rsp0), 64'({LIMP_NOT_READY, 32'h0}));
        check_eq("rst_rsp1",  64'(o_rsp1), 64'({LIMP_NOT_READY, 32'h0}));
        check_eq("rst_owner", 64'(o_owner), 64'd0);
        tick();
        i_rst = 1'b0;
        settle();
        check_eq("post_rst_cmd", 64'(o_req.cmd), 64'(LIMP_NOP));

        // Tie on reads, target always ready: port 0, then port 1, then port 0 again.
        tick();
        do_reset();
        set_req(0, LIMP_READ, 32'h10);
        set_req(1, LIMP_READ, 32'h20);
        set_rsp(LIMP_READY_OK, 32'haa);
        settle();
        check_eq("tie_c0_owner", 64'(o_owner), 64'd0);
        check_eq("tie_c0_addr",  64'(o_req.addr), 64'h10);
        check_eq("tie_c0_rsp0",  64'(o_rsp0), 64'({LIMP_READY_OK, 32'haa}));
        check_eq("tie_c0_rsp1",  64'(o_rsp1.status), 64'(LIMP_NOT_READY));
        tick();
        set_req(0, LIMP_NOP, 32'h0);
        settle();
        check_eq("tie_c1_owner", 64'(o_owner), 64'd1);
        check_eq("tie_c1_addr",  64'(o_req.addr), 64'h20);
        check_eq("tie_c1_rsp1",  64'(o_rsp1.status), 64'(LIMP_READY_OK));
        tick();
        set_req(0, LIMP_READ, 32'h14);
        set_req(1, LIMP_READ, 32'h24);
        settle();
        check_eq("tie_c2_owner", 64'(o_owner), 64'd0);

        // Port 1 write held for 3 wait cycles while port 0 read waits.
        tick();
        do_reset();
        set_req(1, LIMP_WRITE, 32'h100);
        set_rsp(LIMP_NOT_READY, 32'h0);
        for (int c = 0; c < 4; c++) begin
            if (c == 1) set_req(0, LIMP_READ, 32'h40);
            if (c == 3) set_rsp(LIMP_READY_OK, 32'h0);
            settle();
            check_eq($sformatf("lock_c%0d_owner", c), 64'(o_owner), 64'd1);
            check_eq($sformatf("lock_c%0d_addr", c), 64'(o_req.addr), 64'h100);
            check_eq($sformatf("lock_c%0d_cmd", c), 64'(o_req.cmd), 64'(LIMP_WRITE));
            check_eq($sformatf("lock_c%0d_rsp0", c), 64'(o_rsp0.status), 64'(LIMP_NOT_READY));
            tick();
        end
        set_req(1, LIMP_NOP, 32'h0);
        set_rsp(LIMP_READY_OK, 32'h77);
        settle();
        check_eq("lock_c4_owner", 64'(o_owner), 64'd0);
        check_eq("lock_c4_addr",  64'(o_req.addr), 64'h40);
        check_eq("lock_c4_rsp0",  64'(o_rsp0), 64'({LIMP_READY_OK, 32'h77}));

        // AMO sequence on port 0 keeps port 1 out, even across an idle gap.
        tick();
        do_reset();
        set_req(0, LIMP_AMO_READ, 32'h80);
        set_req(1, LIMP_READ, 32'h90);
        set_rsp(LIMP_READY_OK, 32'h1);
        settle();
        check_eq("amo_c0_owner", 64'(o_owner), 64'd0);
        check_eq("amo_c0_cmd",   64'(o_req.cmd), 64'(LIMP_AMO_READ));
        check_eq("amo_c0_rsp1",  64'(o_rsp1.status), 64'(LIMP_NOT_READY));
        tick();
        set_req(0, LIMP_READ, 32'h84);
        settle();
        check_eq("amo_c1_addr", 64'(o_req.addr), 64'h84);
        check_eq("amo_c1_rsp1", 64'(o_rsp1.status), 64'(LIMP_NOT_READY));
        tick();
        set_req(0, LIMP_NOP, 32'h0);
        settle();
        check_eq("amo_gap_cmd",  64'(o_req.cmd), 64'(LIMP_NOP));
        check_eq("amo_gap_rsp1", 64'(o_rsp1.status), 64'(LIMP_NOT_READY));
        tick();
        set_req(0, LIMP_WRITE, 32'h80);
        settle();
        check_eq("amo_wr_owner", 64'(o_owner), 64'd0);
        check_eq("amo_wr_cmd",   64'(o_req.cmd), 64'(LIMP_WRITE));
        check_eq("amo_wr_rsp1",  64'(o_rsp1.status), 64'(LIMP_NOT_READY));
        tick();
        set_req(0, LIMP_NOP, 32'h0);
        settle();
        check_eq("amo_end_owner", 64'(o_owner), 64'd1);
        check_eq("amo_end_addr",  64'(o_req.addr), 64'h90);
        check_eq("amo_end_rsp1",  64'(o_rsp1.status), 64'(LIMP_READY_OK));

        // Continuous tie: fixed priority starves port 1, fair alternates.
        tick();
        do_reset();
        set_req(0, LIMP_READ, 32'h500);
        set_req(1, LIMP_READ, 32'h600);
        set_rsp(LIMP_READY_OK, 32'h3);
        for (int c = 0; c < 8; c++) begin
            settle();
            check_eq($sformatf("fp_c%0d_owner", c), 64'(fp_owner), 64'd0);
            check_eq($sformatf("fp_c%0d_rsp1", c), 64'(fp_rsp1.status), 64'(LIMP_NOT_READY));
            check_eq($sformatf("rr_c%0d_owner", c), 64'(o_owner), 64'(c % 2));
            tick();
        end

        // ILLEGAL answer ends a locked write; port 1 is granted next.
        do_reset();
        set_req(0, LIMP_WRITE, 32'h200);
        set_req(1, LIMP_READ, 32'h300);
        set_rsp(LIMP_NOT_READY, 32'h0);
        settle();
        check_eq("ill_c0_owner", 64'(o_owner), 64'd0);
        tick();
        set_rsp(LIMP_READY_ILLEGAL, 32'h0);
        settle();
        check_eq("ill_c1_rsp0", 64'(o_rsp0.status), 64'(LIMP_READY_ILLEGAL));
        check_eq("ill_c1_rsp1", 64'(o_rsp1.status), 64'(LIMP_NOT_READY));
        tick();
        set_req(0, LIMP_READ, 32'h204);
        set_rsp(LIMP_READY_OK, 32'h9);
        settle();
        check_eq("ill_c2_owner", 64'(o_owner), 64'd1);
        check_eq("ill_c2_rsp1",  64'(o_rsp1), 64'({LIMP_READY_OK, 32'h9}));

        // Owner abandons a locked transfer: NOP forwarded, last grant kept.
        tick();
        do_reset();
        set_req(0, LIMP_READ, 32'h700);
        set_rsp(LIMP_NOT_READY, 32'h0);
        settle();
        check_eq("drop_c0_owner", 64'(o_owner), 64'd0);
        tick();
        set_req(0, LIMP_NOP, 32'h0);
        set_req(1, LIMP_READ, 32'h710);
        set_rsp(LIMP_READY_OK, 32'h0);
        settle();
        check_eq("drop_c1_cmd",  64'(o_req.cmd), 64'(LIMP_NOP));
        check_eq("drop_c1_rsp1", 64'(o_rsp1.status), 64'(LIMP_NOT_READY));
        tick();
        set_req(0, LIMP_READ, 32'h700);
        settle();
        check_eq("drop_c2_owner", 64'(o_owner), 64'd0);

        // Reset while port 1 holds the lock; port 0 then wins the tie.
        tick();
        do_reset();
        set_req(1, LIMP_WRITE, 32'h800);
        set_rsp(LIMP_NOT_READY, 32'h0);
        settle();
        check_eq("rlk_c0_owner", 64'(o_owner), 64'd1);
        tick();
        set_req(0, LIMP_READ, 32'h810);
        i_rst = 1'b1;
        settle();
        check_eq("rlk_c1_owner", 64'(o_owner), 64'd1);
        tick();
        i_rst = 1'b0;
        settle();
        check_eq("rlk_c2_owner", 64'(o_owner), 64'd0);
        check_eq("rlk_c2_addr",  64'(o_req.addr), 64'h810);
        check_eq("rlk_c2_rsp1",  64'(o_rsp1.status), 64'(LIMP_NOT_READY));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
